// File: rtl/spi_master.sv
// SPI mode-0 master: one byte MSB-first per accepted start, select optionally held across bytes.
// Latency: byteDone lands 16*CLK_DIV cycles after the first ssel-low cycle; ssel rises CLK_DIV later.
// Backpressure: start is taken only while ready=1 (IDLE/HOLD); otherwise it is dropped, nothing is queued.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dataToSend,
    input  logic       keepSelect,
    output logic       ready,
    output logic       byteDone,
    output logic [7:0] receivedData,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEAD  = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] TRAIL = 3'd4;

    logic [2:0] state;
    logic [2:0] nextState;
    logic [7:0] divCnt;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic       lastTick;

    assign lastTick = (divCnt == 8'(CLK_DIV - 1));
    assign ready    = (state == IDLE) || (state == HOLD);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (start) nextState = LEAD;
            LEAD:  if (lastTick) nextState = HIGH;
            HIGH: begin
                if (lastTick) begin
                    if (bitCnt != 3'd7) nextState = LEAD;
                    else if (keepSelect) nextState = HOLD;
                    else nextState = TRAIL;
                end
            end
            // start wins over a dropped keepSelect so a back-to-back byte never releases select
            HOLD: begin
                if (start) nextState = LEAD;
                else if (!keepSelect) nextState = TRAIL;
            end
            TRAIL: if (lastTick) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            divCnt       <= 8'd0;
            bitCnt       <= 3'd0;
            shiftReg     <= 8'd0;
            receivedData <= 8'd0;
            byteDone     <= 1'b0;
            sck          <= 1'b0;
            ssel         <= 1'b1;
            mosi         <= 1'b0;
        end else begin
            state    <= nextState;
            byteDone <= 1'b0;
            // pins are registered from the next state so they change cleanly with the state
            sck      <= (nextState == HIGH);
            ssel     <= (nextState == IDLE);

            if (nextState != state || state == IDLE || state == HOLD)
                divCnt <= 8'd0;
            else
                divCnt <= divCnt + 8'd1;

            case (state)
                IDLE, HOLD: begin
                    if (start) begin
                        shiftReg <= dataToSend;
                        mosi     <= dataToSend[7];
                        bitCnt   <= 3'd0;
                    end
                end
                LEAD: begin
                    if (lastTick)
                        shiftReg <= {shiftReg[6:0], miso};
                end
                HIGH: begin
                    if (lastTick) begin
                        if (bitCnt != 3'd7) begin
                            bitCnt <= bitCnt + 3'd1;
                            mosi   <= shiftReg[7];
                        end else begin
                            receivedData <= shiftReg;
                            byteDone     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
